pse_host: RTL and testbench

- Host-side counterpart of the point-sorting engine (PSE).
- Holds a loadable point set of 3..6 points and streams it, one point per cycle, on the engine's Xin/Yin/point_num inputs.
- Collects the sorted vertex stream returned on valid/Xout/Yout into a result buffer and computes twice the polygon area (shoelace) with an orientation flag.
- Sits between the system controller (register-style load/start) and the PSE instance.

---
 rtl/pse_pkg.sv | 10 +
 rtl/pse_host_term.sv | 16 +
 rtl/pse_host.sv | 140 ++++++++++++++
 tb/tb_pse_host.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pse_pkg.sv
// pse_pkg: shared widths, limits and FSM states for the PSE host.
package pse_pkg;
   localparam int CW = 10;
   localparam int NW = 3;
   localparam int MAX_PTS = 6;
   localparam int TW = 21;
   localparam int AW = 23;
   localparam int ACCW = 24;
   typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FINISH, ERROR} state_t;
endpackage

// File: rtl/pse_host_term.sv
// shoelace_term: one cross-product term xa*yb - xb*ya of the shoelace sum,
// returned as a 21-bit two's complement value.
module shoelace_term
   import pse_pkg::*;
(
   input  logic [CW-1:0] xa,
   input  logic [CW-1:0] ya,
   input  logic [CW-1:0] xb,
   input  logic [CW-1:0] yb,
   output logic [TW-1:0] term
);
   logic [2*CW-1:0] p, q;
   assign p = {{CW{1'b0}}, xa} * {{CW{1'b0}}, yb};
   assign q = {{CW{1'b0}}, xb} * {{CW{1'b0}}, ya};
   assign term = {1'b0, p} - {1'b0, q};
endmodule

// File: rtl/pse_host.sv
// pse_host: streams a point set to the PSE, collects the sorted burst and
// computes twice the enclosed polygon area with its orientation.
module pse_host
   import pse_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int MAXPTS = MAX_PTS
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [2:0]    wr_addr,
   input  logic [9:0]    wr_x,
   input  logic [9:0]    wr_y,
   input  logic          start,
   input  logic [2:0]    num,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [22:0]   area2,
   output logic          cw,
   input  logic [2:0]    rd_addr,
   output logic [9:0]    rd_x,
   output logic [9:0]    rd_y,
   output logic [9:0]    pse_xin,
   output logic [9:0]    pse_yin,
   output logic [2:0]    pse_point_num,
   input  logic          pse_valid,
   input  logic [9:0]    pse_xout,
   input  logic [9:0]    pse_yout
);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [NW-1:0] MP = NW'(MAXPTS);
   state_t state, nxt;
   logic [NW-1:0] n, cnt;
   logic [WW-1:0] wcnt;
   logic [CW-1:0] src_x [MAXPTS];
   logic [CW-1:0] src_y [MAXPTS];
   logic [CW-1:0] res_x [MAXPTS];
   logic [CW-1:0] res_y [MAXPTS];
   logic [CW-1:0] xa, ya, xb, yb;
   logic [TW-1:0] term;
   logic signed [ACCW-1:0] acc, sum, mag;
   logic num_ok, fin;
   assign num_ok = num >= NW'(3) && num <= MP;
   assign fin = state == FINISH;
   assign busy = state != IDLE;
   assign rd_x = rd_addr < MP ? res_x[rd_addr] : '0;
   assign rd_y = rd_addr < MP ? res_y[rd_addr] : '0;
   // One multiplier pair: the running term in RECV, the closing edge in FINISH.
   assign xa = fin ? res_x[n - 1'b1] : res_x[cnt - 1'b1];
   assign ya = fin ? res_y[n - 1'b1] : res_y[cnt - 1'b1];
   assign xb = fin ? res_x[0] : pse_xout;
   assign yb = fin ? res_y[0] : pse_yout;
   shoelace_term u_term (.xa(xa), .ya(ya), .xb(xb), .yb(yb), .term(term));
   assign sum = acc + {{(ACCW-TW){term[TW-1]}}, term};
   assign mag = sum[ACCW-1] ? -sum : sum;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= nxt;
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? (num_ok ? SEND : ERROR) : IDLE;
         SEND:    nxt = cnt == n ? WAIT : SEND;
         WAIT:    nxt = pse_valid ? RECV : (wcnt == WW'(TIMEOUT - 1) ? ERROR : WAIT);
         RECV:    nxt = !pse_valid ? ERROR : (cnt == n - 1'b1 ? FINISH : RECV);
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAXPTS; i++) begin
            src_x[i] <= '0;
            src_y[i] <= '0;
            res_x[i] <= '0;
            res_y[i] <= '0;
         end
         n <= '0;
         cnt <= '0;
         wcnt <= '0;
         acc <= '0;
         area2 <= '0;
         cw <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         pse_xin <= '0;
         pse_yin <= '0;
         pse_point_num <= '0;
      end else begin
         done <= fin;
         err <= state == ERROR;
         case (state)
            IDLE: begin
               if (wr_en && wr_addr < MP) begin
                  src_x[wr_addr] <= wr_x;
                  src_y[wr_addr] <= wr_y;
               end
               if (start && num_ok) begin
                  n <= num;
                  pse_point_num <= num;
                  acc <= '0;
                  pse_xin <= src_x[0];
                  pse_yin <= src_y[0];
                  cnt <= NW'(1);
               end
            end
            SEND: begin
               pse_xin <= cnt == n ? '0 : src_x[cnt];
               pse_yin <= cnt == n ? '0 : src_y[cnt];
               cnt <= cnt == n ? cnt : cnt + 1'b1;
               wcnt <= '0;
            end
            WAIT: begin
               wcnt <= wcnt + 1'b1;
               if (pse_valid) begin
                  res_x[0] <= pse_xout;
                  res_y[0] <= pse_yout;
                  cnt <= NW'(1);
               end
            end
            RECV: begin
               if (pse_valid) begin
                  res_x[cnt] <= pse_xout;
                  res_y[cnt] <= pse_yout;
                  acc <= sum;
                  cnt <= cnt + 1'b1;
               end
            end
            FINISH: begin
               area2 <= mag[AW-1:0];
               cw <= sum[ACCW-1];
               pse_point_num <= '0;
            end
            default: pse_point_num <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_pse_host.sv
// tb_pse_host: directed transactions against a transaction-level model of the
// host; one negedge process compares every output each cycle.
module tb_pse_host;
   localparam int TO = 255;
   logic clk = 0, reset = 1, wr_en = 0, start = 0, pse_valid = 0;
   logic [2:0] wr_addr = 0, num = 0, rd_addr = 0;
   logic [9:0] wr_x = 0, wr_y = 0, pse_xout = 0, pse_yout = 0;
   logic busy, done, err, cw;
   logic [22:0] area2;
   logic [9:0] rd_x, rd_y, pse_xin, pse_yin;
   logic [2:0] pse_point_num;

   pse_host #(.TIMEOUT(TO), .MAXPTS(6)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
      .start(start), .num(num), .busy(busy), .done(done), .err(err), .area2(area2), .cw(cw),
      .rd_addr(rd_addr), .rd_x(rd_x), .rd_y(rd_y), .pse_xin(pse_xin), .pse_yin(pse_yin),
      .pse_point_num(pse_point_num), .pse_valid(pse_valid), .pse_xout(pse_xout), .pse_yout(pse_yout)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, fails = 0;
   int m_sx[6], m_sy[6], m_rx[6], m_ry[6], ret_x[8], ret_y[8];
   int m_area2 = 0, t0 = 0, m_n = 0, t_end = 0, e_area = 0;
   bit m_cw = 0, e_cw = 0, act = 0, legal = 0, end_done = 0;

   function automatic void check(string nm, int a, int e);
      checks++;
      if (a != e) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, a, e);
      end
   endfunction

   // Model timeline: rel counts cycles after the edge that samples start.
   always @(negedge clk) begin
      int rel;
      bit on, be;
      rel = cyc - t0;
      on = act && !reset;
      be = on && rel >= 0 && rel < t_end;
      check("busy", busy, be);
      check("done", done, on && rel == t_end && end_done);
      check("err", err, on && rel == t_end && !end_done);
      check("point_num", pse_point_num, (be && legal) ? m_n : 0);
      check("xin", pse_xin, (on && legal && rel >= 0 && rel < m_n) ? m_sx[rel] : 0);
      check("yin", pse_yin, (on && legal && rel >= 0 && rel < m_n) ? m_sy[rel] : 0);
      if (on && rel == t_end) begin
         if (end_done) begin
            m_area2 = e_area;
            m_cw = e_cw;
         end
         act = 0;
      end
      check("area2", area2, m_area2);
      check("cw", cw, m_cw);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(int a, int x, int y);
      wr_en = 1; wr_addr = 3'(a); wr_x = 10'(x); wr_y = 10'(y);
      tick();
      wr_en = 0;
      if (a < 6) begin
         m_sx[a] = x;
         m_sy[a] = y;
      end
   endtask

   task automatic set_ret(int i, int x, int y);
      ret_x[i] = x;
      ret_y[i] = y;
   endtask

   // nm: num, v0: first valid cycle, cnt: valid burst length, rst_at: reset cycle or -1.
   task automatic run(int nm, int v0, int cnt, int rst_at, bit glitch);
      int rel, s;
      legal = nm >= 3 && nm <= 6;
      m_n = nm;
      if (!legal) begin t_end = 1; end_done = 0; end
      else if (cnt == 0) begin t_end = nm + TO + 1; end_done = 0; end
      else if (cnt < nm) begin t_end = v0 + cnt + 2; end_done = 0; end
      else begin t_end = v0 + nm + 1; end_done = 1; end
      s = 0;
      if (end_done)
         for (int i = 0; i < nm; i++) begin
            int j;
            j = (i + 1) % nm;
            s += ret_x[i] * ret_y[j] - ret_x[j] * ret_y[i];
         end
      e_area = s < 0 ? -s : s;
      e_cw = s < 0;
      start = 1; num = 3'(nm); t0 = cyc + 1; act = 1;
      do begin
         tick();
         start = 0;
         rel = cyc - t0;
         if (rel == rst_at) begin
            reset = 1; pse_valid = 0; act = 0; m_area2 = 0; m_cw = 0;
            for (int i = 0; i < 6; i++) begin
               m_sx[i] = 0; m_sy[i] = 0; m_rx[i] = 0; m_ry[i] = 0;
            end
            return;
         end
         if (rel >= v0 && rel < v0 + cnt) begin
            pse_valid = 1; pse_xout = 10'(ret_x[rel - v0]); pse_yout = 10'(ret_y[rel - v0]);
         end else begin
            pse_valid = glitch && rel == 1; pse_xout = 999; pse_yout = 999;
         end
      end while (rel < t_end || rel < v0 + cnt);
      pse_valid = 0;
      if (end_done) begin
         for (int i = 0; i < nm; i++) begin
            m_rx[i] = ret_x[i];
            m_ry[i] = ret_y[i];
         end
         for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            check("rd_x", rd_x, a < 6 ? m_rx[a] : 0);
            check("rd_y", rd_y, a < 6 ? m_ry[a] : 0);
         end
      end
      tick();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 0;
      tick();
      // counter-clockwise square returned in the same order
      load(0, 0, 0); load(1, 10, 0); load(2, 10, 10); load(3, 0, 10);
      set_ret(0, 0, 0); set_ret(1, 10, 0); set_ret(2, 10, 10); set_ret(3, 0, 10);
      run(4, 4 + 5, 4, -1, 0);
      check("sq_area_lit", area2, 200);
      check("sq_cw_lit", cw, 0);
      rd_addr = 2; #1;
      check("sq_rd2_lit", rd_x, 10);
      tick();
      // clockwise return, with two surplus valid cycles afterwards
      set_ret(0, 0, 0); set_ret(1, 0, 10); set_ret(2, 10, 10); set_ret(3, 10, 0);
      set_ret(4, 7, 7); set_ret(5, 8, 8);
      run(4, 4 + 2, 6, -1, 0);
      check("cw_area_lit", area2, 200);
      check("cw_cw_lit", cw, 1);
      // six points at the coordinate extremes, a stray valid during SEND
      load(0, 0, 0); load(1, 1023, 0); load(2, 1023, 512);
      load(3, 1023, 1023); load(4, 0, 1023); load(5, 0, 512); load(6, 77, 77);
      for (int i = 0; i < 6; i++) set_ret(i, m_sx[i], m_sy[i]);
      run(6, 6 + 1, 6, -1, 1);
      check("max_area_lit", area2, 2093058);
      check("max_cw_lit", cw, 0);
      // illegal counts
      run(2, 0, 0, -1, 0);
      run(7, 0, 0, -1, 0);
      // no response from the PSE
      run(4, 0, 0, -1, 0);
      // burst broken after two points
      run(4, 4 + 3, 2, -1, 0);
      check("drop_area_lit", area2, 2093058);
      // reset in the middle of RECV
      load(0, 0, 0); load(1, 10, 0); load(2, 10, 10); load(3, 0, 10);
      set_ret(0, 0, 0); set_ret(1, 10, 0); set_ret(2, 10, 10); set_ret(3, 0, 10);
      run(4, 6, 4, 7, 0);
      rd_addr = 1; #1;
      check("rst_busy_lit", busy, 0);
      check("rst_area_lit", area2, 0);
      check("rst_rd_lit", rd_x, 0);
      check("rst_pn_lit", pse_point_num, 0);
      tick();
      reset = 0;
      tick();
      // triangle after reset
      load(0, 0, 0); load(1, 4, 0); load(2, 0, 3);
      set_ret(0, 0, 0); set_ret(1, 4, 0); set_ret(2, 0, 3);
      run(3, 3 + 1, 3, -1, 0);
      check("tri_area_lit", area2, 12);
      check("tri_cw_lit", cw, 0);
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
